// File: rtl/fp_sqrt_ctrl_if.sv
// rtl/fp_sqrt_ctrl_if.sv - operand/result handshake and core-side signals of fp_sqrt_ctrl
interface fp_sqrt_ctrl_if;
    logic        opValid_i;
    logic        opReady_o;
    logic        opInv_i;
    logic [15:0] op_i;
    logic [15:0] res_o;
    logic        resValid_o;
    logic [8:0]  sqrtS_o;
    logic        doSqrt_o;
    logic        doInvSqrt_o;
    logic [8:0]  sqrtRes_i;
    logic        sqrtValid_i;

    modport master (
        output opValid_i, opInv_i, op_i, sqrtRes_i, sqrtValid_i,
        input  opReady_o, res_o, resValid_o, sqrtS_o, doSqrt_o, doInvSqrt_o
    );

    modport slave (
        input  opValid_i, opInv_i, op_i, sqrtRes_i, sqrtValid_i,
        output opReady_o, res_o, resValid_o, sqrtS_o, doSqrt_o, doInvSqrt_o
    );
endinterface

// File: rtl/fp_sqrt_ctrl.sv
// rtl/fp_sqrt_ctrl.sv - bfloat16 sqrt / inverse-sqrt wrapper around a Q1.8 fractional core
// Optional rounding: define FP_SQRT_ROUND_EN for round-to-nearest (ties up), else truncate.
module fp_sqrt_ctrl (
    input  logic          clk,
    input  logic          rst,
    fp_sqrt_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PACK} state_t;

    state_t      state, state_nxt;
    logic [15:0] op_q;
    logic        inv_q;
    logic        spec_q;
    logic [15:0] spec_res_q;
    logic [7:0]  half_q;
    logic [8:0]  core_q;

    logic        sgn;
    logic [7:0]  ex;
    logic [6:0]  fr;
    logic        special;
    logic [15:0] spec_val;
    logic [8:0]  e_unb;
    logic [7:0]  half;
    logic [8:0]  sqrt_s_val;
    logic        do_sqrt_d, do_inv_d;
    logic [7:0]  er;
    logic [7:0]  exp_sum;
    logic [6:0]  frac_t;
    logic [7:0]  exp_r;
    logic [6:0]  frac_r;
    logic [15:0] pack_res;

    assign sgn = op_q[15];
    assign ex  = op_q[14:7];
    assign fr  = op_q[6:0];

    // Denormals (exp=0) are treated as signed zero, so a negative denormal yields -0, not NaN.
    always_comb begin
        special  = (ex == 8'h00) || (ex == 8'hFF) || sgn;
        spec_val = 16'h7FC0;
        if (ex == 8'hFF && fr != 7'd0) begin
            spec_val = 16'h7FC0;
        end else if (ex == 8'h00) begin
            spec_val = inv_q ? {sgn, 8'hFF, 7'd0} : {sgn, 15'd0};
        end else if (sgn) begin
            spec_val = 16'h7FC0;
        end else begin
            spec_val = inv_q ? 16'h0000 : 16'h7F80;
        end
    end

    // half = Ea/2, where Ea rounds an odd unbiased exponent up to the next even value.
    assign e_unb      = {1'b0, ex} - 9'd127;
    assign half       = e_unb[8:1] + {7'd0, e_unb[0]};
    assign sqrt_s_val = e_unb[0] ? {2'b01, fr} : {1'b1, fr, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.opValid_i)   state_nxt = ISSUE;
            ISSUE:   state_nxt = special ? PACK : WAIT;
            WAIT:    if (bus.sqrtValid_i) state_nxt = PACK;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_sqrt_d = (state == ISSUE) && !special && !inv_q;
        do_inv_d  = (state == ISSUE) && !special &&  inv_q;
        er        = inv_q ? (8'd0 - half_q) : half_q;
        exp_sum   = (core_q[8] ? 8'd127 : 8'd126) + er;
        frac_t    = core_q[8] ? core_q[7:1] : core_q[6:0];
`ifdef FP_SQRT_ROUND_EN
        {exp_r, frac_r} = {exp_sum, frac_t} + {14'd0, core_q[8] & core_q[0]};
`else
        exp_r     = exp_sum;
        frac_r    = frac_t;
`endif
        pack_res  = spec_q ? spec_res_q : {1'b0, exp_r, frac_r};
    end

    assign bus.opReady_o = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q            <= 16'd0;
            inv_q           <= 1'b0;
            spec_q          <= 1'b0;
            spec_res_q      <= 16'd0;
            half_q          <= 8'd0;
            core_q          <= 9'd0;
            bus.res_o       <= 16'd0;
            bus.resValid_o  <= 1'b0;
            bus.sqrtS_o     <= 9'd0;
            bus.doSqrt_o    <= 1'b0;
            bus.doInvSqrt_o <= 1'b0;
        end else begin
            bus.resValid_o  <= (state == PACK);
            bus.doSqrt_o    <= do_sqrt_d;
            bus.doInvSqrt_o <= do_inv_d;
            if (state == IDLE && bus.opValid_i) begin
                op_q  <= bus.op_i;
                inv_q <= bus.opInv_i;
            end
            if (state == ISSUE) begin
                spec_q     <= special;
                spec_res_q <= spec_val;
                half_q     <= half;
                if (!special) bus.sqrtS_o <= sqrt_s_val;
            end
            if (state == WAIT && bus.sqrtValid_i) core_q <= bus.sqrtRes_i;
            if (state == PACK) bus.res_o <= pack_res;
        end
    end
endmodule

// File: tb/tb_fp_sqrt_ctrl.sv
// tb/tb_fp_sqrt_ctrl.sv - directed bench for fp_sqrt_ctrl with a behavioural core stand-in
module tb_fp_sqrt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_sqrt_ctrl_if bus();
    fp_sqrt_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] round_exp;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] op, input logic inv, input logic special,
                          input logic [8:0] exp_s, input logic [8:0] core_res,
                          input logic [15:0] exp_res);
        int n;
        n = 0;
        while (!bus.opReady_o && n < 20) begin
            tick();
            n++;
        end
        check("op_ready", {15'd0, bus.opReady_o}, 16'd1);
        bus.opValid_i = 1'b1;
        bus.op_i      = op;
        bus.opInv_i   = inv;
        tick();
        bus.opValid_i = 1'b0;
        bus.op_i      = 16'(($urandom));
        check("issue_no_pulse", {14'd0, bus.doSqrt_o, bus.doInvSqrt_o}, 16'd0);
        tick();
        exp_q.push_back(exp_res);
        if (special) begin
            check("special_no_pulse", {14'd0, bus.doSqrt_o, bus.doInvSqrt_o}, 16'd0);
        end else begin
            check("start_pulse", {14'd0, bus.doSqrt_o, bus.doInvSqrt_o}, {14'd0, !inv, inv});
            check("sqrt_s", {7'd0, bus.sqrtS_o}, {7'd0, exp_s});
            tick();
            check("pulse_end", {14'd0, bus.doSqrt_o, bus.doInvSqrt_o}, 16'd0);
            repeat (2) begin
                tick();
                check("wait_no_valid", {15'd0, bus.resValid_o}, 16'd0);
            end
            check("sqrt_s_held", {7'd0, bus.sqrtS_o}, {7'd0, exp_s});
            bus.sqrtRes_i   = core_res;
            bus.sqrtValid_i = 1'b1;
            tick();
            bus.sqrtValid_i = 1'b0;
            bus.sqrtRes_i   = 9'(($urandom));
            check("pack_no_valid", {15'd0, bus.resValid_o}, 16'd0);
        end
        tick();
        check("res_valid", {15'd0, bus.resValid_o}, 16'd1);
        check("res", bus.res_o, exp_q.pop_front());
        tick();
        check("res_valid_drop", {15'd0, bus.resValid_o}, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.opValid_i   = 1'b0;
        bus.opInv_i     = 1'b0;
        bus.op_i        = 16'd0;
        bus.sqrtRes_i   = 9'd0;
        bus.sqrtValid_i = 1'b0;
        tick();
        tick();
        check("rst_ready", {15'd0, bus.opReady_o}, 16'd0);
        check("rst_res", bus.res_o, 16'd0);
        check("rst_sqrt_s", {7'd0, bus.sqrtS_o}, 16'd0);
        check("rst_strobes", {13'd0, bus.resValid_o, bus.doSqrt_o, bus.doInvSqrt_o}, 16'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", {15'd0, bus.opReady_o}, 16'd1);

        run_op(16'h4080, 1'b0, 1'b0, 9'h100, 9'h100, 16'h4000);
        run_op(16'h4000, 1'b0, 1'b0, 9'h080, 9'h0B5, 16'h3FB5);
        run_op(16'h4080, 1'b1, 1'b0, 9'h100, 9'h100, 16'h3F00);
        run_op(16'h4000, 1'b1, 1'b0, 9'h080, 9'h0B5, 16'h3EB5);
        run_op(16'h3E80, 1'b0, 1'b0, 9'h100, 9'h100, 16'h3F00);

        run_op(16'hBF80, 1'b0, 1'b1, 9'h000, 9'h000, 16'h7FC0);
        run_op(16'h0000, 1'b1, 1'b1, 9'h000, 9'h000, 16'h7F80);
        run_op(16'h8000, 1'b1, 1'b1, 9'h000, 9'h000, 16'hFF80);
        run_op(16'h8000, 1'b0, 1'b1, 9'h000, 9'h000, 16'h8000);
        run_op(16'h0001, 1'b0, 1'b1, 9'h000, 9'h000, 16'h0000);
        run_op(16'h7F80, 1'b0, 1'b1, 9'h000, 9'h000, 16'h7F80);
        run_op(16'h7F80, 1'b1, 1'b1, 9'h000, 9'h000, 16'h0000);
        run_op(16'hFF80, 1'b0, 1'b1, 9'h000, 9'h000, 16'h7FC0);
        run_op(16'h7FC1, 1'b0, 1'b1, 9'h000, 9'h000, 16'h7FC0);

`ifdef FP_SQRT_ROUND_EN
        round_exp = 16'h4000;
`else
        round_exp = 16'h3FFF;
`endif
        run_op(16'h3F80, 1'b0, 1'b0, 9'h100, 9'h1FF, round_exp);

        bus.opValid_i = 1'b1;
        bus.op_i      = 16'h4080;
        bus.opInv_i   = 1'b0;
        tick();
        bus.opValid_i = 1'b0;
        tick();
        tick();
        check("wait_sqrt_s", {7'd0, bus.sqrtS_o}, 16'h0100);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {15'd0, bus.opReady_o}, 16'd0);
        check("mid_rst_res", bus.res_o, 16'd0);
        check("mid_rst_sqrt_s", {7'd0, bus.sqrtS_o}, 16'd0);
        check("mid_rst_strobes", {13'd0, bus.resValid_o, bus.doSqrt_o, bus.doInvSqrt_o}, 16'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", {15'd0, bus.opReady_o}, 16'd1);
        bus.sqrtRes_i   = 9'h100;
        bus.sqrtValid_i = 1'b1;
        tick();
        bus.sqrtValid_i = 1'b0;
        repeat (3) begin
            tick();
            check("late_valid_ignored", {15'd0, bus.resValid_o}, 16'd0);
        end
        run_op(16'h4080, 1'b0, 1'b0, 9'h100, 9'h100, 16'h4000);

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp_sqrt_ctrl.md
# fp_sqrt_ctrl

- Floating-point front/back end for the fractional square-root core `core_SQRT`.
- Accepts a bfloat16 operand and an op select (sqrt / inverse sqrt) through a valid/ready handshake.
- Filters special cases, halves the exponent and aligns the mantissa into the core's Q1.8 input.
- Launches the core, waits for its result, then normalizes, optionally rounds and repacks a bfloat16 result.

## Interface
Parameters: none.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `opValid_i`  in  1  operand valid
- `opReady_o`  out  1  block can accept an operand
- `opInv_i`  in  1  0 = sqrt, 1 = inverse sqrt
- `op_i`  in  16  bfloat16 operand {sign, exp[7:0], frac[6:0]}, bias 127
- `res_o`  out  16  bfloat16 result
- `resValid_o`  out  1  one-cycle result strobe, no backpressure
- `sqrtS_o`  out  9  core operand, Q1.8 (bit 8 weight 1)
- `doSqrt_o`, `doInvSqrt_o`  out  1  one-cycle core start pulses
- `sqrtRes_i`  in  9  core result, Q1.8
- `sqrtValid_i`  in  1  core result valid

## Operation
- FSM states: IDLE, ISSUE, WAIT, PACK.
- IDLE:
  - `opReady_o`=1. Forced to 0 while `rst` is high.
  - On `opValid_i`, register `op_i` and `opInv_i`, then go to ISSUE.
- ISSUE classifies the registered operand. Denormals (exp=0) are flushed to ±0.
  - NaN (exp=FF, frac≠0): result 0x7FC0.
  - Negative nonzero, including -inf: result 0x7FC0.
  - ±0: sqrt gives ±0 (sign kept). Invsqrt gives ±inf (0x7F80/0xFF80).
  - +inf: sqrt gives 0x7F80. Invsqrt gives 0x0000.
  - Special case: go to PACK. The core is not started.
  - Normal case:
    - Let E = exp−127.
    - E even: `sqrtS_o`={1,frac,0} and Ea=E.
    - E odd: `sqrtS_o`={0,1,frac} and Ea=E+1.
    - Pulse `doSqrt_o` or `doInvSqrt_o` per op, then go to WAIT.
- WAIT:
  - `sqrtS_o` is held stable.
  - The first cycle with `sqrtValid_i`=1 captures `sqrtRes_i` and moves to PACK.
  - `sqrtValid_i` is ignored in every other state.
- PACK:
  - Er = Ea/2 for sqrt, −Ea/2 for invsqrt. Sign is always 0.
  - `sqrtRes_i[8]`=1: frac=`res[7:1]`, round bit=`res[0]`, biased exp=127+Er.
  - `sqrtRes_i[8]`=0: the core guarantees `res[7]`=1. frac=`res[6:0]`, no round bit, biased exp=126+Er.
  - Rounding: see Configuration. A frac carry-out clears frac and increments exp.
  - The result always stays in range; no overflow or underflow logic.
  - Register `res_o`, assert `resValid_o`, go to IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `res_o`=0, `sqrtS_o`=0.
  - `resValid_o`, `doSqrt_o`, `doInvSqrt_o` all 0.
- Operand accepted at edge T:
  - ISSUE during T..T+1.
  - Start pulse high exactly one cycle, T+1..T+2.
- Special case: `resValid_o` high one cycle after edge T+2.
- Normal case: `sqrtValid_i` sampled high at edge W gives `resValid_o` high one cycle after edge W+1.
- A new operand may be accepted in the same cycle `resValid_o` is high, because the FSM is in IDLE. There is no other overlap.
- Asynchronous `rst` mid-operation, in any state:
  - Immediate return to IDLE with outputs at reset values.
  - The in-flight operand is discarded.
  - A late `sqrtValid_i` after reset is ignored.

## Configuration
- `FP_SQRT_ROUND_EN` defined: round-to-nearest, ties up, using the round bit. Carry propagates into the exponent.
- Not defined: truncate. The round bit is ignored and there is no incrementer.

## Test plan
- sqrt 0x4080 (4.0): `sqrtS_o`=0x100, `doSqrt_o` pulse. Core model returns 0x100 → `res_o`=0x4000.
- sqrt 0x4000 (2.0): `sqrtS_o`=0x080. Core returns 0x0B5 → `res_o`=0x3FB5.
- invsqrt 0x4080: `doInvSqrt_o` pulse, `sqrtS_o`=0x100. Core returns 0x100 → `res_o`=0x3F00.
- Specials, no start pulse, `resValid_o` 3 edges after accept:
  - sqrt 0xBF80 → 0x7FC0.
  - invsqrt 0x0000 → 0x7F80.
  - sqrt 0x7F80 → 0x7F80.
  - invsqrt 0x7F80 → 0x0000.
  - sqrt 0x7FC1 → 0x7FC0.
- Rounding, sqrt 0x3F80 with core returning 0x1FF → `res_o`=0x4000 with `FP_SQRT_ROUND_EN`, 0x3FFF without.
- Reset in WAIT: assert `rst` before `sqrtValid_i`, release it, then pulse `sqrtValid_i` → no `resValid_o`. `opReady_o`=1 after release. The next operation sqrt 0x4080 yields 0x4000.
